// File: rtl/prog_counter_pkg.sv
// Shared encodings for the programmable tile counter.
// No logic; constants only.
// No flow control.
package prog_counter_pkg;

    localparam logic MODE_WRAP = 1'b0;
    localparam logic MODE_SAT  = 1'b1;

    localparam logic DIR_DOWN  = 1'b0;
    localparam logic DIR_UP    = 1'b1;

endpackage

// File: rtl/counter_prescaler.sv
// Enable prescaler: pulses tick once every prescale+1 enabled cycles.
// Latency: tick is combinational from the phase register.
// No backpressure; en=0 freezes the phase, clr restarts it.
module counter_prescaler #(
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  clr,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic                  tick
);

    logic [PRESCALE_W-1:0] pre_cnt;
    logic                  hit;

    assign hit  = (pre_cnt == prescale);
    assign tick = en & ~clr & hit;

    // A phase already past a reduced prescale runs on to its natural wrap.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pre_cnt <= '0;
        end else if (clr) begin
            pre_cnt <= '0;
        end else if (en) begin
            pre_cnt <= hit ? '0 : pre_cnt + 1'b1;
        end
    end

endmodule

// File: rtl/prog_counter.sv
// Up/down counter with modulo top, wrap/saturate, load and boundary flags.
// Latency: count/tc registered, one clk after the deciding edge.
// No backpressure; load > tick > hold every cycle.
module prog_counter
    import prog_counter_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int PRESCALE_W = 8
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  en,
    input  logic                  up,
    input  logic                  mode,
    input  logic                  load,
    input  logic [WIDTH-1:0]      load_val,
    input  logic [WIDTH-1:0]      max_val,
    input  logic [PRESCALE_W-1:0] prescale,
    output logic [WIDTH-1:0]      count,
    output logic                  tc,
    output logic                  at_top,
    output logic                  at_zero
);

    logic             tick;
    logic [WIDTH-1:0] count_nxt;
    logic             tc_nxt;

    counter_prescaler #(
        .PRESCALE_W (PRESCALE_W)
    ) u_prescaler (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .clr      (load),
        .prescale (prescale),
        .tick     (tick)
    );

    always_comb begin
        count_nxt = count;
        tc_nxt    = 1'b0;
        if (load) begin
            count_nxt = load_val;
        end else if (tick) begin
            if (up == DIR_UP) begin
                // >= so a count stranded above a lowered max_val is treated as top
                if (count >= max_val) begin
                    tc_nxt = 1'b1;
                    if (mode == MODE_WRAP) count_nxt = '0;
                end else begin
                    count_nxt = count + 1'b1;
                end
            end else begin
                if (count == '0) begin
                    tc_nxt = 1'b1;
                    if (mode == MODE_WRAP) count_nxt = max_val;
                end else begin
                    count_nxt = count - 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count <= '0;
            tc    <= 1'b0;
        end else begin
            count <= count_nxt;
            tc    <= tc_nxt;
        end
    end

    assign at_top  = (count >= max_val);
    assign at_zero = (count == '0);

endmodule

// File: tb/tb_prog_counter.sv
// Randomised and directed checks of prog_counter against an arithmetic model.
module tb_prog_counter;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       en, up, mode, load;
    logic [7:0] load_val, max_val, prescale;
    logic [7:0] count;
    logic       tc, at_top, at_zero;

    int checks   = 0;
    int failures = 0;

    int m_count, m_pre, m_tc;

    always #5 clk = ~clk;

    prog_counter #(.WIDTH(8), .PRESCALE_W(8)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .en       (en),
        .up       (up),
        .mode     (mode),
        .load     (load),
        .load_val (load_val),
        .max_val  (max_val),
        .prescale (prescale),
        .count    (count),
        .tc       (tc),
        .at_top   (at_top),
        .at_zero  (at_zero)
    );

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference: counter value and prescaler phase as plain integers.
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_count <= 0;
            m_pre   <= 0;
            m_tc    <= 0;
        end else if (load) begin
            m_count <= int'(load_val);
            m_pre   <= 0;
            m_tc    <= 0;
        end else if (en && m_pre == int'(prescale)) begin
            m_pre <= 0;
            if (up) begin
                if (m_count >= int'(max_val)) begin
                    m_tc    <= 1;
                    m_count <= mode ? m_count : 0;
                end else begin
                    m_tc    <= 0;
                    m_count <= m_count + 1;
                end
            end else begin
                if (m_count == 0) begin
                    m_tc    <= 1;
                    m_count <= mode ? 0 : int'(max_val);
                end else begin
                    m_tc    <= 0;
                    m_count <= m_count - 1;
                end
            end
        end else begin
            m_tc <= 0;
            if (en) m_pre <= (m_pre + 1) % 256;
        end
    end

    always @(negedge clk) begin
        if (rst_n) begin
            chk("model_count", int'(count), m_count);
            chk("model_tc", int'(tc), m_tc);
            chk("model_at_top", int'(at_top), int'(m_count >= int'(max_val)));
            chk("model_at_zero", int'(at_zero), int'(m_count == 0));
        end
    end

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n = 1'b0; en = 1'b0; up = 1'b1; mode = 1'b0; load = 1'b0;
        load_val = 8'h00; max_val = 8'hFF; prescale = 8'h00;
        #1;
        chk("reset_count", int'(count), 0);
        chk("reset_tc", int'(tc), 0);
        cyc(); cyc();
        rst_n = 1'b1;

        // Asynchronous reset while holding 0x37
        load = 1'b1; load_val = 8'h37;
        cyc();
        chk("pre_reset_count", int'(count), 8'h37);
        load = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("async_reset_count", int'(count), 0);
        chk("async_reset_tc", int'(tc), 0);
        cyc();
        rst_n = 1'b1; en = 1'b1; up = 1'b1; prescale = 8'd0; max_val = 8'hFF;
        cyc(); chk("post_reset_1", int'(count), 1);
        cyc(); chk("post_reset_2", int'(count), 2);
        cyc(); chk("post_reset_3", int'(count), 3);

        // Up wrap at full range
        load = 1'b1; load_val = 8'hFE; mode = 1'b0;
        cyc(); chk("upwrap_fe", int'(count), 8'hFE);
        load = 1'b0;
        cyc(); chk("upwrap_ff", int'(count), 8'hFF); chk("upwrap_top", int'(at_top), 1);
        chk("upwrap_tc_ff", int'(tc), 0);
        cyc(); chk("upwrap_00", int'(count), 0); chk("upwrap_tc", int'(tc), 1);
        cyc(); chk("upwrap_01", int'(count), 1); chk("upwrap_tc_off", int'(tc), 0);

        // Down wrap modulo 10
        max_val = 8'd9; load = 1'b1; load_val = 8'd1; up = 1'b0;
        cyc(); chk("dnwrap_1", int'(count), 1);
        load = 1'b0;
        cyc(); chk("dnwrap_0", int'(count), 0); chk("dnwrap_zero", int'(at_zero), 1);
        cyc(); chk("dnwrap_9", int'(count), 9); chk("dnwrap_tc", int'(tc), 1);
        cyc(); chk("dnwrap_8", int'(count), 8); chk("dnwrap_tc_off", int'(tc), 0);

        // Saturate at 5
        max_val = 8'd5; load = 1'b1; load_val = 8'd4; up = 1'b1; mode = 1'b1;
        cyc(); chk("sat_4", int'(count), 4);
        load = 1'b0;
        cyc(); chk("sat_5a", int'(count), 5); chk("sat_tc_a", int'(tc), 0);
        cyc(); chk("sat_5b", int'(count), 5); chk("sat_tc_b", int'(tc), 1);
        cyc(); chk("sat_5c", int'(count), 5); chk("sat_tc_c", int'(tc), 1);
        up = 1'b0;
        cyc(); chk("sat_down_4", int'(count), 4); chk("sat_down_tc", int'(tc), 0);

        // Prescale 3 with an enable gap
        max_val = 8'hFF; mode = 1'b0; up = 1'b1; prescale = 8'd3;
        load = 1'b1; load_val = 8'd0;
        cyc(); load = 1'b0;
        for (int i = 1; i <= 3; i++) begin
            cyc(); chk("pre_hold0", int'(count), 0);
        end
        cyc(); chk("pre_first_tick", int'(count), 1);
        cyc(); cyc();
        en = 1'b0;
        for (int i = 0; i < 5; i++) begin
            cyc(); chk("en_frozen", int'(count), 1);
        end
        en = 1'b1;
        cyc(); chk("resume_phase", int'(count), 1);
        cyc(); chk("resume_tick", int'(count), 2);

        // Load beats a wrapping tick and restarts the prescaler
        prescale = 8'd1; load = 1'b1; load_val = 8'hFF;
        cyc(); load = 1'b0;
        cyc(); chk("lp_armed", int'(count), 8'hFF);
        load = 1'b1; load_val = 8'h20;
        cyc(); chk("lp_load", int'(count), 8'h20); chk("lp_tc", int'(tc), 0);
        load = 1'b0;
        cyc(); chk("lp_restart", int'(count), 8'h20);
        cyc(); chk("lp_tick", int'(count), 8'h21);

        // Random traffic, model-checked on every falling edge
        for (int i = 0; i < 3000; i++) begin
            en       = ($urandom_range(0, 3) != 0);
            up       = 1'($urandom);
            mode     = ($urandom_range(0, 7) == 0) ? ~mode : mode;
            load     = ($urandom_range(0, 15) == 0);
            load_val = 8'($urandom);
            if ($urandom_range(0, 31) == 0)
                max_val = ($urandom_range(0, 1) != 0) ? 8'hFF : 8'($urandom_range(1, 20));
            if ($urandom_range(0, 63) == 0)
                prescale = 8'($urandom_range(0, 3));
            if ($urandom_range(0, 255) == 0) begin
                rst_n = 1'b0;
                #2 rst_n = 1'b1;
            end
            cyc();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
